// File: rtl/qr_pkg.sv
// rtl/qr_pkg.sv - shared QR datapath widths, FSM state type and magnitude-squared helper
package qr_pkg;

   localparam int DATA_W      = 12;
   localparam int SUM_W       = 33;
   localparam int SQRT_STAGES = 6;

   localparam logic [SUM_W-1:0] SAT_MAX = '1;

   typedef enum logic {
      ACC   = 1'b0,
      ISSUE = 1'b1
   } state_t;

   // re^2 + im^2; each square fits 2*DATA_W bits, so the sum needs one more
   function automatic logic [2*DATA_W:0] mag_sq(input logic signed [DATA_W-1:0] re,
                                                input logic signed [DATA_W-1:0] im);
      logic signed [2*DATA_W-1:0] re_x;
      logic signed [2*DATA_W-1:0] im_x;
      logic signed [2*DATA_W-1:0] sq_re;
      logic signed [2*DATA_W-1:0] sq_im;
      re_x  = {{DATA_W{re[DATA_W-1]}}, re};
      im_x  = {{DATA_W{im[DATA_W-1]}}, im};
      sq_re = re_x * re_x;
      sq_im = im_x * im_x;
      return {1'b0, sq_re} + {1'b0, sq_im};
   endfunction

endpackage

// File: rtl/col_norm_sq_feeder_if.sv
// rtl/col_norm_sq_feeder_if.sv - element stream, sqrt-pipe control and root handshake bundle
interface col_norm_sq_feeder_if;
   import qr_pkg::*;

   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_re;
   logic signed [DATA_W-1:0] in_im;
   logic                     in_last;
   logic                     sqrt_en;
   logic [SUM_W-1:0]         sqrt_a;
   logic                     root_valid;
   logic                     out_ready;
   logic                     len_err;

   modport master (
      output in_valid, in_re, in_im, in_last, out_ready,
      input  in_ready, sqrt_en, sqrt_a, root_valid, len_err
   );

   modport slave (
      input  in_valid, in_re, in_im, in_last, out_ready,
      output in_ready, sqrt_en, sqrt_a, root_valid, len_err
   );

endinterface

// File: rtl/sqrt_tag_pipe.sv
// rtl/sqrt_tag_pipe.sv - enabled shift register marking live operands in a stall-mode pipe
module sqrt_tag_pipe #(
   parameter int STAGES = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic din,
   output logic dout
);

   logic [STAGES-1:0] tags;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tags <= '0;
      end else if (en) begin
         tags[0] <= din;
         for (int i = 1; i < STAGES; i++) begin
            tags[i] <= tags[i-1];
         end
      end
   end

   assign dout = tags[STAGES-1];

endmodule

// File: rtl/col_norm_sq_feeder.sv
// rtl/col_norm_sq_feeder.sv - accumulates |x|^2 over a column and launches it into the sqrt pipe
module col_norm_sq_feeder
   import qr_pkg::*;
#(
   parameter int N_ELEM = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   col_norm_sq_feeder_if.slave  bus
);

   localparam int              CNT_W    = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ELEM - 1);

   state_t            state;
   state_t            state_nxt;
   logic [SUM_W-1:0]  acc;
   logic [SUM_W-1:0]  acc_nxt;
   logic [SUM_W:0]    sum_wide;
   logic [2*DATA_W:0] term;
   logic [CNT_W-1:0]  cnt;
   logic              accept;
   logic              at_max;
   logic              close;
   logic              launch;
   logic              tag_in;
   logic              len_err_q;

   assign accept = bus.in_valid && bus.in_ready;
   assign at_max = (cnt == CNT_LAST);
   assign close  = accept && (bus.in_last || at_max);

   // Whole pipe freezes only while a finished root is refused downstream
   assign bus.sqrt_en = ~(bus.root_valid & ~bus.out_ready);
   assign launch      = (state == ISSUE) && bus.sqrt_en;

   assign term     = mag_sq(bus.in_re, bus.in_im);
   assign sum_wide = {1'b0, acc} + (SUM_W+1)'(term);
   assign acc_nxt  = sum_wide[SUM_W] ? SAT_MAX : sum_wide[SUM_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ACC;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACC:     if (close)  state_nxt = ISSUE;
         ISSUE:   if (launch) state_nxt = ACC;
         default: state_nxt = ACC;
      endcase
   end

   always_comb begin
      bus.in_ready = 1'b0;
      bus.sqrt_a   = '0;
      tag_in       = 1'b0;
      case (state)
         ACC: bus.in_ready = 1'b1;
         ISSUE: begin
            bus.sqrt_a = acc;
            tag_in     = 1'b1;
         end
         default: bus.in_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         cnt       <= '0;
         len_err_q <= 1'b0;
      end else begin
         // Short column (last early) or forced close (last missing) both flag
         len_err_q <= close && (bus.in_last != at_max);
         if (launch) begin
            acc <= '0;
            cnt <= '0;
         end else if (accept) begin
            acc <= acc_nxt;
            if (!close) begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   assign bus.len_err = len_err_q;

   sqrt_tag_pipe #(
      .STAGES (SQRT_STAGES - 1)
   ) u_tag_pipe (
      .clk  (clk),
      .rst  (rst),
      .en   (bus.sqrt_en),
      .din  (tag_in),
      .dout (bus.root_valid)
   );

endmodule

// File: tb/tb_col_norm_sq_feeder.sv
// tb/tb_col_norm_sq_feeder.sv - directed bench with a behavioural stall-mode sqrt pipe beside the feeder
module tb_col_norm_sq_feeder;
   import qr_pkg::*;

   logic clk = 1'b0;
   logic rst;

   col_norm_sq_feeder_if bus ();

   col_norm_sq_feeder #(
      .N_ELEM (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int     cyc = 0;
   int     last_acc_cyc = 0;
   int     lerr_cnt = 0;
   int     lerr_cyc = 0;
   int     total = 0;
   int     passed = 0;
   longint root_val_q[$];
   longint root_cyc_q[$];
   longint launch_val_q[$];
   longint launch_cyc_q[$];
   logic [SUM_W-1:0] ops [SQRT_STAGES-1];

   function automatic longint isqrt(input longint x);
      longint r;
      r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      return r;
   endfunction

   function automatic longint at(input longint q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Operand pipe of the external sqrt unit, advancing only with sqrt_en
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SQRT_STAGES - 1; i++) ops[i] <= '0;
      end else if (bus.sqrt_en) begin
         ops[0] <= bus.sqrt_a;
         for (int i = 1; i < SQRT_STAGES - 1; i++) ops[i] <= ops[i-1];
      end
   end

   always @(negedge clk) begin
      if (bus.in_valid && bus.in_ready) last_acc_cyc = cyc;
      if (!rst && !bus.in_ready && bus.sqrt_en) begin
         launch_val_q.push_back(longint'(bus.sqrt_a));
         launch_cyc_q.push_back(longint'(cyc));
      end
      if (bus.root_valid && bus.out_ready) begin
         root_val_q.push_back(isqrt(longint'(ops[SQRT_STAGES-2])));
         root_cyc_q.push_back(longint'(cyc));
      end
      if (bus.len_err) begin
         lerr_cnt++;
         lerr_cyc = cyc;
      end
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      root_val_q.delete();
      root_cyc_q.delete();
      launch_val_q.delete();
      launch_cyc_q.delete();
      lerr_cnt = 0;
   endtask

   task automatic send(input int re, input int im, input bit last);
      bit ok;
      int n;
      bus.in_re    = re[DATA_W-1:0];
      bus.in_im    = im[DATA_W-1:0];
      bus.in_last  = last;
      bus.in_valid = 1'b1;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 64) begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if (!ok) check("send_timeout", 0, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},   bus.in_ready,   1);
      check({tag, "_sqrt_en"},    bus.sqrt_en,    1);
      check({tag, "_sqrt_a"},     bus.sqrt_a,     0);
      check({tag, "_root_valid"}, bus.root_valid, 0);
      check({tag, "_len_err"},    bus.len_err,    0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int col_re [6];
      int col_im [6];
      int col_rt [6];
      col_re = '{1, 2, 0, 7, 10, -12};
      col_im = '{0, 0, 6, 0, 10, 5};
      col_rt = '{2, 5, 16, 19, 40, 36};

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_re     = '0;
      bus.in_im     = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      tick(3);
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");
      tick(1);

      // Single column of (3,4) x8
      clear_log();
      for (int i = 0; i < 8; i++) send(3, 4, i == 7);
      t = last_acc_cyc;
      @(negedge clk);
      check("single_issue_in_ready", bus.in_ready, 0);
      check("single_issue_sqrt_a", bus.sqrt_a, 200);
      tick(1);
      @(negedge clk);
      check("single_in_ready_back", bus.in_ready, 1);
      tick(10);
      check("single_launch_val", at(launch_val_q, 0), 200);
      check("single_launch_lat", at(launch_cyc_q, 0) - t, 1);
      check("single_root", at(root_val_q, 0), 14);
      check("single_root_lat", at(root_cyc_q, 0) - t, SQRT_STAGES);
      check("single_root_count", root_val_q.size(), 1);
      check("single_len_err", lerr_cnt, 0);

      // Short column, extreme negative inputs
      clear_log();
      send(-2048, -2048, 1'b0);
      send(-2048, -2048, 1'b1);
      t = last_acc_cyc;
      tick(10);
      check("short_launch_val", at(launch_val_q, 0), 16777216);
      check("short_len_err_cnt", lerr_cnt, 1);
      check("short_len_err_cyc", lerr_cyc - t, 1);
      check("short_root", at(root_val_q, 0), 4096);
      check("short_root_lat", at(root_cyc_q, 0) - t, SQRT_STAGES);

      // Six back-to-back columns
      clear_log();
      for (int c = 0; c < 6; c++)
         for (int e = 0; e < 8; e++) send(col_re[c], col_im[c], e == 7);
      tick(12);
      check("b2b_root_count", root_val_q.size(), 6);
      for (int c = 0; c < 6; c++) check($sformatf("b2b_root%0d", c), at(root_val_q, c), col_rt[c]);
      for (int c = 1; c < 6; c++)
         check($sformatf("b2b_spacing%0d", c), at(root_cyc_q, c) - at(root_cyc_q, c - 1), 9);
      check("b2b_len_err", lerr_cnt, 0);

      // Backpressure: root held while the next column waits in ISSUE
      clear_log();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(3, 4, i == 7);
      for (int i = 0; i < 8; i++) send(1, 1, i == 7);
      tick(4);
      @(negedge clk);
      check("bp_root_valid", bus.root_valid, 1);
      check("bp_sqrt_en", bus.sqrt_en, 0);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_sqrt_a", bus.sqrt_a, 16);
      check("bp_launch_count", launch_val_q.size(), 1);
      check("bp_root_count_held", root_val_q.size(), 0);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      tick(10);
      check("bp_root_count", root_val_q.size(), 2);
      check("bp_root0", at(root_val_q, 0), 14);
      check("bp_root1", at(root_val_q, 1), 4);
      check("bp_launch1", at(launch_val_q, 1), 16);

      // Forced close: in_last never asserted
      clear_log();
      for (int i = 0; i < 8; i++) send(1, 0, 1'b0);
      t = last_acc_cyc;
      tick(10);
      check("forced_launch_val", at(launch_val_q, 0), 8);
      check("forced_len_err_cnt", lerr_cnt, 1);
      check("forced_len_err_cyc", lerr_cyc - t, 1);
      check("forced_root", at(root_val_q, 0), 2);

      // Reset two cycles after launch discards the in-flight root
      clear_log();
      for (int i = 0; i < 8; i++) send(3, 4, i == 7);
      tick(2);
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      tick(2);
      rst = 1'b0;
      tick(12);
      check("midrst_no_root", root_val_q.size(), 0);
      clear_log();
      send(0, 5, 1'b1);
      tick(10);
      check("post_rst_launch_count", launch_val_q.size(), 1);
      check("post_rst_launch_val", at(launch_val_q, 0), 25);
      check("post_rst_root", at(root_val_q, 0), 5);
      check("post_rst_len_err", lerr_cnt, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
